// File: rtl/muldiv_unit_if.sv
// muldiv_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   master (pipeline): drives start, op, a, b, flush; observes busy, done, result
//   slave  (muldiv)  : observes the request; drives busy, done, result
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, flush, input busy, done, result);
  modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with fixed 33-cycle latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if slave (start/op/a/b/flush in; busy/done/result out)
// Multiply is shift-add on operand magnitudes, LSB first; divide is restoring,
// MSB first. Signs are applied, and the architected divide-by-zero and
// overflow results are selected, in the FIN cycle.
module muldiv_unit (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d;
  logic [31:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  // Multiply: shifting multiplier. Divide: dividend in, quotient out.
  logic [31:0] sh_q, sh_d;
  // Multiply: 64-bit product. Divide: partial remainder in [32:0].
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d, busy_q, busy_d;

  // Combinational helpers
  logic        sgn_a_s, sgn_b_s;
  logic [32:0] sum_s, rem_sh_s, diff_s;
  logic        ge_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, a_raw_s, fin_s;
  logic        div0_s, ovf_s;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_sgn_d  = a_sgn_q;
    b_sgn_d  = b_sgn_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;

    // Request-side sign decode: MULH/DIV/REM signed both, MULHSU signed rs1 only
    sgn_a_s = ((bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) ||
               (bus.op == 3'b110)) ? bus.a[31] : 1'b0;
    sgn_b_s = ((bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110)) ?
              bus.b[31] : 1'b0;

    // One iteration step for each algorithm
    sum_s    = {1'b0, acc_q[63:32]} + (sh_q[0] ? {1'b0, a_mag_q} : 33'd0);
    rem_sh_s = {acc_q[31:0], sh_q[31]};
    diff_s   = rem_sh_s - {1'b0, b_mag_q};
    ge_s     = (rem_sh_s >= {1'b0, b_mag_q});

    // FIN sign fix-up and special cases
    prod_s  = (a_sgn_q ^ b_sgn_q) ? (~acc_q + 64'd1) : acc_q;
    quot_s  = (a_sgn_q ^ b_sgn_q) ? (~sh_q + 32'd1) : sh_q;
    rem_s   = a_sgn_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    a_raw_s = a_sgn_q ? (~a_mag_q + 32'd1) : a_mag_q;
    div0_s  = (b_mag_q == 32'd0);
    ovf_s   = a_sgn_q && (a_mag_q == 32'h8000_0000) && b_sgn_q && (b_mag_q == 32'd1);

    case (op_q)
      3'b000:                 fin_s = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin_s = prod_s[63:32];
      3'b100:                 fin_s = div0_s ? 32'hFFFF_FFFF : (ovf_s ? 32'h8000_0000 : quot_s);
      3'b101:                 fin_s = div0_s ? 32'hFFFF_FFFF : sh_q;
      3'b110:                 fin_s = div0_s ? a_raw_s : (ovf_s ? 32'd0 : rem_s);
      3'b111:                 fin_s = div0_s ? a_mag_q : acc_q[31:0];
      default:                fin_s = 32'd0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_sgn_d = sgn_a_s;
          b_sgn_d = sgn_b_s;
          a_mag_d = sgn_a_s ? (~bus.a + 32'd1) : bus.a;
          b_mag_d = sgn_b_s ? (~bus.b + 32'd1) : bus.b;
          // Divide shifts the dividend out MSB-first; multiply shifts rs2 LSB-first
          sh_d    = bus.op[2] ? (sgn_a_s ? (~bus.a + 32'd1) : bus.a) :
                                (sgn_b_s ? (~bus.b + 32'd1) : bus.b);
          acc_d   = 64'd0;
          cnt_d   = 6'd0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = {31'd0, (ge_s ? diff_s : rem_sh_s)};
          sh_d  = {sh_q[30:0], ge_s};
        end else begin
          acc_d = {sum_s, acc_q[31:1]};
          sh_d  = {1'b0, sh_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIN: begin
        result_d = fin_s;
        done_d   = 1'b1;
        cnt_d    = 6'd0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything, including a same-cycle start or FIN
    if (bus.flush) begin
      state_d  = S_IDLE;
      cnt_d    = 6'd0;
      done_d   = 1'b0;
      result_d = result_q;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      a_mag_q  <= 32'd0;
      b_mag_q  <= 32'd0;
      sh_q     <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_sgn_q  <= a_sgn_d;
      b_sgn_q  <= b_sgn_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end
endmodule
